// File: rtl/n_bit_sipo_rx.sv
`default_nettype none
// ============================================================================
// Module   : n_bit_sipo_rx
// Purpose  : Serial-in/parallel-out frame receiver (start, n data MSB-first,
//            stop) with valid/ready output buffer and sticky error flags.
//            Optional even-parity bit enabled by N_BIT_SIPO_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module n_bit_sipo_rx #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         din,
    input  logic         bit_en,
    output logic [n-1:0] Q,
    output logic         q_valid,
    input  logic         q_ready,
    output logic         frame_err,
    output logic         overrun,
    output logic         busy
`ifdef N_BIT_SIPO_PARITY_EN
    ,
    output logic         parity_err
`endif
);

    localparam int            CW     = $clog2(n);
    localparam logic [CW-1:0] c_LAST = CW'(n - 1);

`ifdef N_BIT_SIPO_PARITY_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_STOP = 2'd2, S_PARITY = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_STOP = 2'd2} state_t;
`endif

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [n-1:0]    r_shift;
    logic            w_word_ok;
    logic            w_can_load;

`ifdef N_BIT_SIPO_PARITY_EN
    logic            r_par_bad;
    assign w_word_ok = ~r_par_bad;
`else
    assign w_word_ok = 1'b1;
`endif

    // Buffer can take a new word if empty or being drained on this same edge.
    assign w_can_load = ~q_valid | q_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            Q         <= '0;
            q_valid   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
`ifdef N_BIT_SIPO_PARITY_EN
            r_par_bad  <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            if (q_valid && q_ready) begin
                q_valid <= 1'b0;
            end
            if (bit_en) begin
                case (r_state)
                    S_IDLE: begin
                        if (!din) begin
                            r_state <= S_DATA;
                            r_cnt   <= '0;
                            busy    <= 1'b1;
`ifdef N_BIT_SIPO_PARITY_EN
                            r_par_bad <= 1'b0;
`endif
                        end
                    end
                    S_DATA: begin
                        r_shift <= {r_shift[n-2:0], din};
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST) begin
`ifdef N_BIT_SIPO_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
`ifdef N_BIT_SIPO_PARITY_EN
                    S_PARITY: begin
                        // Even parity: the parity bit equals the XOR of the data bits.
                        if (din != ^r_shift) begin
                            r_par_bad  <= 1'b1;
                            parity_err <= 1'b1;
                        end
                        r_state <= S_STOP;
                    end
`endif
                    S_STOP: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        if (!din) begin
                            frame_err <= 1'b1;
                        end else if (w_word_ok) begin
                            if (w_can_load) begin
                                Q       <= r_shift;
                                q_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/n_bit_sipo_rx.md
Name: n_bit_sipo_rx

Overview:
- Serial-in/parallel-out receiver: the far end of an N-bit parallel-to-serial link.
- Detects a start bit, shifts in N data bits MSB-first, checks the stop bit, then presents the word on a parallel output with a valid/ready handshake.
- Sits between a serial line (driven by a matching PISO transmitter) and a parallel register consumer.

Parameters:
- n, 4, data word width in bits (n >= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- din  input  1  serial line; idles high.
- bit_en  input  1  bit strobe; line sampled only on clk edges with bit_en=1.
- Q  output  n  received word; valid while q_valid=1.
- q_valid  output  1  word available.
- q_ready  input  1  consumer accepts word when q_valid & q_ready at a clk edge.
- frame_err  output  1  sticky; stop bit sampled as 0.
- overrun  output  1  sticky; a completed word was dropped because the buffer was still full.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset: sampled only on clk edges with rst_n=0. Sets state=IDLE, Q=0, q_valid=0, frame_err=0, overrun=0, busy=0, bit counter=0, shift register=0. Reset mid-frame abandons the frame; no partial word is ever presented.
- Frame format: start(0), n data bits MSB-first, stop(1).
- FSM (advances only on edges with bit_en=1, except the handshake):
  - IDLE: din=0 -> DATA, counter=0. din=1 -> stay in IDLE.
  - DATA: shift din into the LSB of the shift register (shift left), counter+1. After the n-th bit go to STOP. The counter is log2-sized and never wraps inside a frame.
  - STOP: din=1 -> deliver word, go to IDLE. din=0 -> set frame_err, discard the word, go to IDLE. The next start bit is searched from the following strobe; no extra idle bit is required.
- Deliver word:
  - q_valid=0, or q_valid=1 with q_ready=1 on this same edge: load Q from the shift register and set q_valid=1 (back-to-back, zero bubble).
  - Otherwise: set overrun; Q and q_valid stay unchanged; the new word is lost.
- Handshake: q_valid & q_ready with no simultaneous delivery -> q_valid=0 on the next edge. Q holds its last value after acceptance. q_ready is ignored while q_valid=0.
- Latency: q_valid rises on the clk edge that samples the stop bit, i.e. n+2 strobes after the start-bit strobe, counted inclusively.
- bit_en=0: FSM, counter and shift register hold. The handshake still operates every clk.
- frame_err and overrun are cleared only by reset.
- busy=1 in DATA and STOP.

Optional Feature:
- Macro: N_BIT_SIPO_PARITY_EN.
- Defined:
  - Frame is start, n data bits, one even-parity bit, stop. FSM gains a PARITY state between DATA and STOP.
  - Adds output port parity_err (1 bit, sticky, reset 0).
  - Parity mismatch sets parity_err and the word is discarded at STOP even if the stop bit is good.
  - Latency becomes n+3 strobes.
- Undefined: no PARITY state, no parity_err port, frame exactly as above.

Test Plan:
- Reset, then bit_en=1 every clk and q_ready=1; send frame for 12 (0,1,1,0,0,1) -> Q=4'b1100, q_valid high exactly one clk, frame_err=0, overrun=0.
- Sequences 12, 8, 7, 15 sent back-to-back with q_ready=1 -> Q shows 12, 8, 7, 15 in order, one q_valid pulse per frame, busy low only between frames.
- q_ready=0; send 8, then 7 -> Q stays 8, q_valid stays 1, overrun=1. Then q_ready=1 -> q_valid drops next clk, Q=8.
- Send 15 with stop bit 0 -> q_valid never rises, frame_err=1. A following good frame for 7 is still received correctly.
- bit_en high every 3rd clk, send 7 -> Q=7. FSM state unchanged on clks where bit_en=0. rst_n=0 mid-DATA -> all outputs 0 next edge, and a subsequent frame is received correctly.
- With N_BIT_SIPO_PARITY_EN: send 7 with parity bit 1 -> Q=7. Send 7 with parity bit 0 -> parity_err=1, no q_valid.
